// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// Each stage resolves BLOCKS_PER_STAGE select blocks; the whole pipe advances in lock-step.
module pipelined_csel_adder #(
  parameter int WIDTH            = 16,
  parameter int BLOCK            = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int SW      = BLOCK * BLOCKS_PER_STAGE;
  localparam int NSTAGES = WIDTH / SW;

  if ((WIDTH % SW) != 0 || WIDTH < SW) begin : g_bad_cfg
    $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of BLOCK*BLOCKS_PER_STAGE");
  end

  // Ripple a single block; returns {carry_out, sum}.
  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                            input logic [BLOCK-1:0] y,
                                            input logic             ci);
    logic [BLOCK:0]   c;
    logic [BLOCK-1:0] s;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
    return {c[BLOCK], s};
  endfunction

  logic               adv;
  logic [NSTAGES-1:0] v_d, v_q;
  logic [NSTAGES-1:0] c_d, c_q;
  logic [WIDTH-1:0]   a_d   [NSTAGES];
  logic [WIDTH-1:0]   a_q   [NSTAGES];
  logic [WIDTH-1:0]   bx_d  [NSTAGES];
  logic [WIDTH-1:0]   bx_q  [NSTAGES];
  logic [WIDTH-1:0]   sum_d [NSTAGES];
  logic [WIDTH-1:0]   sum_q [NSTAGES];
  logic               ovf_d, ovf_q;

  assign adv = !v_q[NSTAGES-1] || out_ready;

  for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
    logic [WIDTH-1:0]            st_a, st_bx, st_sum, st_out;
    logic                        st_c;
    logic [BLOCKS_PER_STAGE:0]   bc;
    logic [SW-1:0]               ss;

    if (gi == 0) begin : g_in
      assign st_a    = a;
      assign st_bx   = sub ? ~b : b;
      assign st_sum  = '0;
      assign st_c    = sub | cin;
      assign v_d[gi] = in_valid & adv;
    end else begin : g_mid
      assign st_a    = a_q[gi-1];
      assign st_bx   = bx_q[gi-1];
      assign st_sum  = sum_q[gi-1];
      assign st_c    = c_q[gi-1];
      assign v_d[gi] = v_q[gi-1];
    end

    assign bc[0] = st_c;
    for (genvar gj = 0; gj < BLOCKS_PER_STAGE; gj++) begin : g_blk
      localparam int LO   = gj * BLOCK;
      localparam int BASE = gi * SW + LO;
      logic [BLOCK:0] r;
      if (gi == 0 && gj == 0) begin : g_ripple
        assign r = ripple(st_a[BASE +: BLOCK], st_bx[BASE +: BLOCK], bc[gj]);
      end else begin : g_csel
        logic [BLOCK:0] r0, r1;
        assign r0 = ripple(st_a[BASE +: BLOCK], st_bx[BASE +: BLOCK], 1'b0);
        assign r1 = ripple(st_a[BASE +: BLOCK], st_bx[BASE +: BLOCK], 1'b1);
        assign r  = bc[gj] ? r1 : r0;
      end
      assign ss[LO +: BLOCK] = r[BLOCK-1:0];
      assign bc[gj+1]        = r[BLOCK];
    end

    // Lower bits come from earlier stages, this stage fills its own slice.
    always_comb begin
      st_out              = st_sum;
      st_out[gi*SW +: SW] = ss;
    end

    assign a_d[gi]   = st_a;
    assign bx_d[gi]  = st_bx;
    assign sum_d[gi] = st_out;
    assign c_d[gi]   = bc[BLOCKS_PER_STAGE];

    if (gi == NSTAGES - 1) begin : g_last
      // Carry into the MSB is recovered as a^bx^sum at that bit.
      assign ovf_d = bc[BLOCKS_PER_STAGE] ^ st_a[WIDTH-1] ^ st_bx[WIDTH-1] ^ ss[SW-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q                <= '0;
      sum_q[NSTAGES-1]   <= '0;
      c_q[NSTAGES-1]     <= 1'b0;
      ovf_q              <= 1'b0;
    end else if (adv) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NSTAGES; k++) begin
        a_q[k]   <= a_d[k];
        bx_q[k]  <= bx_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[NSTAGES-1];
  assign sum       = sum_q[NSTAGES-1];
  assign cout      = c_q[NSTAGES-1];
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench for pipelined_csel_adder: default config plus 32/4/1 and 8/8/1 instances.
// Expected results are queued at drive time and popped when a result transfers out.
module tb_pipelined_csel_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: defaults (16/4/2, latency 2)
  logic        iv0 = 0, ir0, ov0, or0 = 1, cin0 = 0, sub0 = 0, co0, of0;
  logic [15:0] a0 = 0, b0 = 0, sum0;
  // Instance 1: 32/4/1 (latency 8)
  logic        iv1 = 0, ir1, ov1, or1 = 1, cin1 = 0, sub1 = 0, co1, of1;
  logic [31:0] a1 = 0, b1 = 0, sum1;
  // Instance 2: 8/8/1 (latency 1)
  logic        iv2 = 0, ir2, ov2, or2 = 1, cin2 = 0, sub2 = 0, co2, of2;
  logic [7:0]  a2 = 0, b2 = 0, sum2;

  pipelined_csel_adder dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(cin0),
    .sub(sub0), .out_valid(ov0), .out_ready(or0), .sum(sum0), .cout(co0), .overflow(of0));
  pipelined_csel_adder #(.WIDTH(32), .BLOCK(4), .BLOCKS_PER_STAGE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(co1), .overflow(of1));
  pipelined_csel_adder #(.WIDTH(8), .BLOCK(8), .BLOCKS_PER_STAGE(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(cin2),
    .sub(sub2), .out_valid(ov2), .out_ready(or2), .sum(sum2), .cout(co2), .overflow(of2));

  int total = 0;
  int bad   = 0;
  logic [33:0] q0[$], q1[$], q2[$];  // {overflow, cout, sum zero-extended to 32}

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: wide integer arithmetic, overflow from operand/result sign agreement.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic s);
    logic [63:0] mask, xe, bxe, full;
    logic [31:0] sm;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    xe   = {32'b0, x} & mask;
    bxe  = s ? (~{32'b0, y}) & mask : {32'b0, y} & mask;
    full = xe + bxe + (s ? 64'd1 : {63'b0, c});
    sm   = 32'(full & mask);
    co   = full[w];
    ov   = (xe[w-1] == bxe[w-1]) && (sm[w-1] != xe[w-1]);
    return {ov, co, sm};
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the operands were accepted.
  task automatic send(input int sel, input logic [31:0] x, input logic [31:0] y,
                      input logic c, input logic s, input logic [33:0] e);
    logic ok;
    case (sel)
      0: begin a0 = x[15:0]; b0 = y[15:0]; cin0 = c; sub0 = s; iv0 = 1; q0.push_back(e); end
      1: begin a1 = x;       b1 = y;       cin1 = c; sub1 = s; iv1 = 1; q1.push_back(e); end
      default: begin a2 = x[7:0]; b2 = y[7:0]; cin2 = c; sub2 = s; iv2 = 1; q2.push_back(e); end
    endcase
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = rdy(sel);
    end
    if (!ok) chk($sformatf("accept_timeout_%0d", sel), 34'(rdy(sel)), 34'd1);
    @(posedge clk); #1;
    case (sel)
      0: iv0 = 0;
      1: iv1 = 0;
      default: iv2 = 0;
    endcase
  endtask

  task automatic send_rand(input int sel, input int w);
    logic [31:0] x, y, m;
    logic        c, s;
    m = 32'((64'd1 << w) - 64'd1);
    x = $urandom() & m;
    y = $urandom() & m;
    c = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    send(sel, x, y, c, s, model(w, x, y, c, s));
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (q0.size() + q1.size() + q2.size()) != 0; n++) @(negedge clk);
    chk("drain_q0", 34'(q0.size()), 34'd0);
    chk("drain_q1", 34'(q1.size()), 34'd0);
    chk("drain_q2", 34'(q2.size()), 34'd0);
    @(posedge clk); #1;
  endtask

  // Output side: transfers happen at the next posedge when valid&ready at this negedge.
  logic        stall_prev = 0;
  logic [33:0] prev0 = '0;
  always @(negedge clk) begin
    logic [33:0] cur0;
    cur0 = {of0, co0, 16'b0, sum0};
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("d0_hold", cur0, prev0);
      if (ov0 && !or0) chk("d0_inready_stall", 34'(ir0), 34'd0);
      if (ov0 && or0) begin
        if (q0.size() == 0) chk("d0_spurious", 34'(ov0), 34'd0);
        else chk("d0_result", cur0, q0.pop_front());
      end
      if (ov1 && or1) begin
        if (q1.size() == 0) chk("d1_spurious", 34'(ov1), 34'd0);
        else chk("d1_result", {of1, co1, sum1}, q1.pop_front());
      end
      if (ov2 && or2) begin
        if (q2.size() == 0) chk("d2_spurious", 34'(ov2), 34'd0);
        else chk("d2_result", {of2, co2, 24'b0, sum2}, q2.pop_front());
      end
      stall_prev = ov0 && !or0;
    end
    prev0 = cur0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [3:0] pat = 4'b1001;
  logic       sweep_done = 0;

  initial begin
    // Reset with operands offered: nothing may be accepted.
    iv0 = 1; a0 = 16'h1234; b0 = 16'h4321;
    repeat (2) @(posedge clk);
    #1; rst = 0; iv0 = 0;
    @(negedge clk);
    chk("rst_out_valid", 34'(ov0), 34'd0);
    chk("rst_sum", 34'(sum0), 34'd0);
    chk("rst_cout_ovf", {32'b0, co0, of0}, 34'd0);
    chk("rst_in_ready", 34'(ir0), 34'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_result", 34'(ov0), 34'd0);
    end
    @(posedge clk); #1;

    // Directed add/sub with latency check on the first one.
    send(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000});
    @(negedge clk);
    chk("latency_early", 34'(ov0), 34'd0);
    @(negedge clk);
    chk("latency_valid", 34'(ov0), 34'd1);
    @(posedge clk); #1;
    drain();
    send(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000});
    send(0, 32'h0005, 32'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFE});
    send(0, 32'h8000, 32'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF});
    drain();

    // Backpressure: 8 back-to-back random ops, out_ready toggling 1,0,0,1.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(0, 16);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          or0 = pat[i % 4];
          @(posedge clk); #1;
        end
        or0 = 1;
      end
    join
    drain();

    // Reset mid-stream: in-flight results must vanish.
    for (int i = 0; i < 3; i++) send_rand(0, 16);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_flush", 34'(ov0), 34'd0);
    @(posedge clk); #1;
    send(0, 32'd1, 32'd2, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0003});
    drain();

    // Parameter sweep with random consumer stalls.
    fork
      begin
        fork
          begin for (int i = 0; i < 1000; i++) send_rand(1, 32); end
          begin for (int i = 0; i < 1000; i++) send_rand(2, 8); end
        join
        sweep_done = 1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk); #1;
          or1 = ($urandom_range(0, 3) != 0);
          or2 = ($urandom_range(0, 3) != 0);
        end
        or1 = 1; or2 = 1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
